// File: rtl/alu_mc_if.sv
// Handshake/bus bundle for the multi-cycle ALU.
//   master side (ALU control): drives start, gin, a, b; observes ready, done,
//                              sum and the Z/N/V flags.
//   slave side  (alu_mc):      the mirror image.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;   // request, accepted only while ready=1
    logic [2:0]       gin;     // ALU control encoding
    logic [WIDTH-1:0] a;       // operand A
    logic [WIDTH-1:0] b;       // operand B
    logic             ready;   // IDLE or DONE: a new start is accepted
    logic             done;    // one-cycle completion pulse
    logic [WIDTH-1:0] sum;     // result, held until the next completion
    logic             zout;    // sum == 0
    logic             nout;    // sum[WIDTH-1]
    logic             vout;    // overflow (ADD/SUB/MUL only)

    modport master (
        output start, gin, a, b,
        input  ready, done, sum, zout, nout, vout
    );

    modport slave (
        input  start, gin, a, b,
        output ready, done, sum, zout, nout, vout
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered Z/N/V flags.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; abandons any in-flight operation
//   bus    : alu_mc_if slave port (start/gin/a/b in, ready/done/sum/flags out)
// Single-cycle ops (AND, OR, ADD, PASS, SUB, SLT) complete on the accepting
// edge. SLLV shifts one bit per BUSY cycle; MUL is an unsigned shift-add
// consuming one multiplier bit per BUSY cycle. Result and flags are written
// only on the edge that enters DONE.
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [SW-1:0]      r_shamt;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc;       // SLLV working value
    logic [2*WIDTH-1:0] r_prod;      // MUL partial product
    logic [2*WIDTH-1:0] r_mcand;     // MUL multiplicand, shifted left each step
    logic [WIDTH-1:0]   r_mplier;    // MUL multiplier, shifted right each step
    logic [WIDTH-1:0]   r_sum;
    logic               r_zout;
    logic               r_nout;
    logic               r_vout;
    logic               r_done;
    logic               r_ready;

    logic [WIDTH-1:0]   w_add;
    logic [WIDTH-1:0]   w_sub;
    logic               w_add_v;
    logic               w_sub_v;
    logic [SW-1:0]      w_shamt_in;
    logic [WIDTH-1:0]   w_quick_res;
    logic               w_quick_v;
    logic [WIDTH-1:0]   w_shl;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_sllv_last;
    logic               w_mul_last;

    // Result of an op that finishes on the accepting edge, taken straight
    // from the bus so it can be registered together with the operand latch.
    always_comb begin
        w_add      = bus.a + bus.b;
        w_sub      = bus.a + ~bus.b + WIDTH'(1);
        w_add_v    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (w_add[WIDTH-1] != bus.a[WIDTH-1]);
        w_sub_v    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
        w_shamt_in = bus.b[SW-1:0];
        w_quick_res = '0;
        w_quick_v   = 1'b0;
        case (bus.gin)
            OP_AND:  w_quick_res = bus.a & bus.b;
            OP_OR:   w_quick_res = bus.a | bus.b;
            OP_ADD:  begin w_quick_res = w_add; w_quick_v = w_add_v; end
            OP_SUB:  begin w_quick_res = w_sub; w_quick_v = w_sub_v; end
            // True signed less-than: the subtraction sign is wrong exactly
            // when the subtraction overflowed.
            OP_SLT:  w_quick_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_v};
            OP_PASS: w_quick_res = bus.a;
            OP_SLLV: w_quick_res = bus.a;   // only reached with shamt == 0
            default: w_quick_res = '0;      // MUL with the multiplier disabled
        endcase
    end

    always_comb begin
        w_shl       = r_acc << 1;
        w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
        w_sllv_last = (r_cnt == ({1'b0, r_shamt} - CW'(1)));
        w_mul_last  = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_AND;
            r_shamt  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sum    <= '0;
            r_zout   <= 1'b0;
            r_nout   <= 1'b0;
            r_vout   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                    if (bus.start) begin
                        r_op    <= bus.gin;
                        r_shamt <= w_shamt_in;
                        r_cnt   <= '0;
                        if (bus.gin == OP_SLLV && w_shamt_in != '0) begin
                            r_acc   <= bus.a;
                            r_ready <= 1'b0;
                            r_state <= S_BUSY;
                        end else if (bus.gin == OP_MUL && MUL_EN) begin
                            r_prod   <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
                            r_mplier <= bus.b;
                            r_ready  <= 1'b0;
                            r_state  <= S_BUSY;
                        end else begin
                            r_sum   <= w_quick_res;
                            r_zout  <= (w_quick_res == '0);
                            r_nout  <= w_quick_res[WIDTH-1];
                            r_vout  <= w_quick_v;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op == OP_SLLV) begin
                        r_acc <= w_shl;
                        if (w_sllv_last) begin
                            r_sum   <= w_shl;
                            r_zout  <= (w_shl == '0);
                            r_nout  <= w_shl[WIDTH-1];
                            r_vout  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_prod   <= w_prod_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        if (w_mul_last) begin
                            r_sum   <= w_prod_next[WIDTH-1:0];
                            r_zout  <= (w_prod_next[WIDTH-1:0] == '0);
                            r_nout  <= w_prod_next[WIDTH-1];
                            r_vout  <= |w_prod_next[2*WIDTH-1:WIDTH];
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.zout  = r_zout;
    assign bus.nout  = r_nout;
    assign bus.vout  = r_vout;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic straight from the opcode definitions.
    task automatic model(input logic [2:0] g, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] s, output logic v, output int lat);
        longint       wide;
        logic [63:0]  wv;
        logic [63:0]  p;
        int           sh;
        s = 0; v = 0; lat = 1;
        case (g)
            3'b000: s = a & b;
            3'b001: s = a | b;
            3'b010: begin
                wide = longint'($signed(a)) + longint'($signed(b));
                wv = wide; s = wv[31:0];
                v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b110: begin
                wide = longint'($signed(a)) - longint'($signed(b));
                wv = wide; s = wv[31:0];
                v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            3'b111: s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b100: s = a;
            3'b011: begin sh = int'(b[4:0]); s = a << sh; lat = sh + 1; end
            default: begin
                p = 64'(a) * 64'(b);
                s = p[31:0]; v = |p[63:32]; lat = W + 1;
            end
        endcase
    endtask

    // Issue one op, scramble the bus inputs after acceptance, wait for done.
    task automatic run_op(input logic [2:0] g, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] s, output logic z, output logic n,
                          output logic v, output int lat, output int busy_cycles,
                          output logic rdy_after);
        @(negedge clk);
        bus.start = 1'b1; bus.gin = g; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.gin = 3'($urandom);
        rdy_after = bus.ready;
        lat = 1; busy_cycles = 0;
        while (!bus.done && lat < 200) begin
            if (!bus.ready) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) begin
            bad++; total++;
            $display("FAIL timeout: gin=%0b no done within %0d cycles", g, lat);
        end
        s = bus.sum; z = bus.zout; n = bus.nout; v = bus.vout;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  g;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] es;
        logic        ez;
        logic        en;
        logic        ev;
        int          elat;
    } vec_t;

    vec_t vt[14];

    initial begin
        logic [31:0] s, ms, a, b;
        logic z, n, v, mv, rdy;
        logic [2:0] g;
        int lat, mlat, bc, done_cnt;

        bus.start = 0; bus.gin = 0; bus.a = 0; bus.b = 0;

        vt[0]  = '{"add_ovf",  3'b010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 1, 1};
        vt[1]  = '{"sub_zero", 3'b110, 32'h5,        32'h5,        32'h0,        1, 0, 0, 1};
        vt[2]  = '{"slt_neg",  3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        0, 0, 0, 1};
        vt[3]  = '{"slt_ovf",  3'b111, 32'h80000000, 32'h1,        32'h1,        0, 0, 0, 1};
        vt[4]  = '{"sllv5",    3'b011, 32'h1,        32'h25,       32'h20,       0, 0, 0, 6};
        vt[5]  = '{"sllv0",    3'b011, 32'h1,        32'h0,        32'h1,        0, 0, 0, 1};
        vt[6]  = '{"mul_a",    3'b101, 32'hFFFF,     32'h10001,    32'hFFFFFFFF, 0, 1, 0, 33};
        vt[7]  = '{"mul_ovf",  3'b101, 32'h10000,    32'h10000,    32'h0,        1, 0, 1, 33};
        vt[8]  = '{"sub_mneg", 3'b110, 32'h0,        32'h80000000, 32'h80000000, 0, 1, 1, 1};
        vt[9]  = '{"and",      3'b000, 32'hF0F0,     32'hFF00,     32'hF000,     0, 0, 0, 1};
        vt[10] = '{"or",       3'b001, 32'hF0F0,     32'hFF00,     32'hFFF0,     0, 0, 0, 1};
        vt[11] = '{"pass",     3'b100, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 0, 1, 0, 1};
        vt[12] = '{"sllv_hib", 3'b011, 32'h3,        32'hFFFFFFE1, 32'h6,        0, 0, 0, 2};
        vt[13] = '{"sllv31",   3'b011, 32'h1,        32'h1F,       32'h80000000, 0, 1, 0, 32};

        // reset state
        #12;
        check("rst_sum", bus.sum, 0);
        check("rst_flags", {bus.zout, bus.nout, bus.vout}, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.ready, 1);
        @(negedge clk); rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].g, vt[i].a, vt[i].b, s, z, n, v, lat, bc, rdy);
            check({vt[i].name, "_sum"}, s, vt[i].es);
            check({vt[i].name, "_zn"}, {z, n}, {vt[i].ez, vt[i].en});
            check({vt[i].name, "_v"}, v, vt[i].ev);
            check({vt[i].name, "_lat"}, lat, vt[i].elat);
            if (vt[i].elat == 1) check({vt[i].name, "_ready"}, rdy, 1);
            else check({vt[i].name, "_busy"}, bc, vt[i].elat - 1);
            $display("vec %s gin=%0b a=%h b=%h sum=%h z%0b n%0b v%0b lat=%0d",
                     vt[i].name, vt[i].g, vt[i].a, vt[i].b, s, z, n, v, lat);
        end

        // start while BUSY is ignored
        @(negedge clk);
        bus.start = 1; bus.gin = 3'b101; bus.a = 32'h1234; bus.b = 32'h10;
        @(posedge clk); #1; bus.start = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1; bus.gin = 3'b010; bus.a = 32'h1; bus.b = 32'h1;
        @(negedge clk); bus.start = 0;
        lat = 0;
        while (!bus.done && lat < 100) begin @(posedge clk); #1; lat++; end
        check("busy_ign_sum", bus.sum, 32'h12340);
        check("busy_ign_done", bus.done, 1);
        $display("busy-start ignored: sum=%h", bus.sum);
        @(posedge clk); #1;
        check("busy_ign_nodup", bus.done, 0);

        // reset in flight
        @(negedge clk);
        bus.start = 1; bus.gin = 3'b101; bus.a = 32'h3; bus.b = 32'h5;
        @(posedge clk); #1; bus.start = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_sum", bus.sum, 0);
        check("midrst_flags", {bus.zout, bus.nout, bus.vout}, 0);
        check("midrst_ready", {bus.ready, bus.done}, 2'b10);
        @(negedge clk); rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) done_cnt++; end
        check("midrst_nodone", done_cnt, 0);
        run_op(3'b010, 32'd20, 32'd22, s, z, n, v, lat, bc, rdy);
        check("postrst_add", s, 32'd42);
        $display("reset in flight: no done, then add sum=%h", s);

        // back-to-back: OR then ADD issued in the OR's DONE cycle
        @(negedge clk);
        bus.start = 1; bus.gin = 3'b001; bus.a = 32'h0F; bus.b = 32'hF0;
        @(posedge clk); #1;
        check("b2b_or_done", bus.done, 1);
        check("b2b_or_sum", bus.sum, 32'hFF);
        bus.gin = 3'b010; bus.a = 32'h10; bus.b = 32'h20;
        @(posedge clk); #1; bus.start = 0;
        check("b2b_add_done", bus.done, 1);
        check("b2b_add_sum", bus.sum, 32'h30);
        @(posedge clk); #1;
        check("b2b_idle", {bus.done, bus.ready}, 2'b01);
        $display("back-to-back OR then ADD sum=%h", 32'h30);

        // random against the model
        for (int i = 0; i < 150; i++) begin
            g = 3'($urandom);
            a = $urandom; b = $urandom;
            if (i % 4 == 0) a = 32'h80000000;
            if (i % 5 == 0) b = (i % 10 == 0) ? 32'h7FFFFFFF : a;
            model(g, a, b, ms, mv, mlat);
            run_op(g, a, b, s, z, n, v, lat, bc, rdy);
            check("rnd_sum", s, ms);
            check("rnd_flags", {z, n, v}, {ms == 0, ms[31], mv});
            check("rnd_lat", lat, mlat);
            $display("rnd %0d gin=%0b a=%h b=%h sum=%h exp=%h lat=%0d", i, g, a, b, s, ms, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
